// File: rtl/arbitro_registrador.sv
// rtl/arbitro_registrador.sv - round-robin arbiter and write sequencer in front of a shared load-enabled register
module arbitro_registrador #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   dado,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         reg_entrada,
    output logic                     reg_load,
    output logic                     ocupado,
    output logic [1:0]               dono
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] CARREGA  = 2'd1;
    localparam logic [1:0] CONFIRMA = 2'd2;

    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [1:0]       LAST_IDX  = 2'(N_REQ - 1);

    logic [1:0]       r_estado;
    logic [1:0]       r_prio;
    logic [1:0]       r_win;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic [WIDTH-1:0] r_entrada;
    logic             r_load;
    logic             r_ocupado;
    logic [1:0]       r_dono;

    logic             w_found;
    logic [1:0]       w_win;
    logic [2:0]       w_sum;

    // Rotating-priority search: walk the order backwards so the last hit kept
    // is the first requester at or after r_prio.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_sum   = 3'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_prio} + 3'(k);
            if (w_sum >= 3'(N_REQ)) begin
                w_sum = w_sum - 3'(N_REQ);
            end
            if (req[w_sum[1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[1:0];
            end
        end
    end

    // Three-phase write sequence: idle -> load the register -> acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= OCIOSO;
            r_prio    <= 2'd0;
            r_win     <= 2'd0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_entrada <= '0;
            r_load    <= 1'b0;
            r_ocupado <= 1'b0;
            r_dono    <= 2'd0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_found) begin
                        r_win     <= w_win;
                        r_entrada <= dado[int'(w_win)*WIDTH +: WIDTH];
                        r_load    <= 1'b1;
                        r_gnt     <= ONE_HOT_0 << w_win;
                        r_ocupado <= 1'b1;
                        r_estado  <= CARREGA;
                    end
                end
                CARREGA: begin
                    // The register captures r_entrada at this edge.
                    r_load    <= 1'b0;
                    r_gnt     <= '0;
                    r_ack     <= ONE_HOT_0 << r_win;
                    r_dono    <= r_win;
                    r_prio    <= (r_win == LAST_IDX) ? 2'd0 : r_win + 2'd1;
                    r_estado  <= CONFIRMA;
                end
                CONFIRMA: begin
                    r_ack     <= '0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_load    <= 1'b0;
                    r_gnt     <= '0;
                    r_ack     <= '0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign ack         = r_ack;
    assign reg_entrada = r_entrada;
    assign reg_load    = r_load;
    assign ocupado     = r_ocupado;
    assign dono        = r_dono;

endmodule

// File: tb/tb_arbitro_registrador.sv
// tb/tb_arbitro_registrador.sv - directed self-checking bench for arbitro_registrador
module tb_arbitro_registrador;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] d [4];
    logic [63:0] dado;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [15:0] reg_entrada;
    logic        reg_load;
    logic        ocupado;
    logic [1:0]  dono;

    logic [15:0] m_reg = 16'h0;
    int n_checks = 0;
    int n_errors = 0;

    assign dado = {d[3], d[2], d[1], d[0]};

    arbitro_registrador #(.N_REQ(4), .WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .dado        (dado),
        .gnt         (gnt),
        .ack         (ack),
        .reg_entrada (reg_entrada),
        .reg_load    (reg_load),
        .ocupado     (ocupado),
        .dono        (dono)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared holding register.
    always @(posedge clk) begin
        if (reg_load) m_reg <= reg_entrada;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    // One complete transaction for requester w, whose request was driven before
    // the current sampling edge. Ends on the negedge after the FSM is idle again.
    task automatic txn(input logic [1:0] w, input logic [15:0] data,
                       input bit drop, input bit scramble, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        step;
        chk({tag, ".gnt"},      32'(gnt),         32'(oh));
        chk({tag, ".load"},     32'(reg_load),    32'd1);
        chk({tag, ".entrada"},  32'(reg_entrada), 32'(data));
        chk({tag, ".ocupado1"}, 32'(ocupado),     32'd1);
        chk({tag, ".ack_pre"},  32'(ack),         32'd0);
        if (scramble) d[w] = 16'hFFFF;
        step;
        chk({tag, ".ack"},      32'(ack),         32'(oh));
        chk({tag, ".gnt_off"},  32'(gnt),         32'd0);
        chk({tag, ".load_off"}, 32'(reg_load),    32'd0);
        chk({tag, ".reg"},      32'(m_reg),       32'(data));
        chk({tag, ".dono"},     32'(dono),        32'(w));
        if (drop) req[w] = 1'b0;
        step;
        chk({tag, ".ack_off"},  32'(ack),         32'd0);
        chk({tag, ".idle"},     32'(ocupado),     32'd0);
        chk({tag, ".hold"},     32'(reg_entrada), 32'(data));
    endtask

    initial begin
        // Reset with activity on the inputs
        rst_n = 1'b0;
        req   = 4'b1011;
        for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
        step;
        step;
        chk("rst.gnt",     32'(gnt),         32'd0);
        chk("rst.ack",     32'(ack),         32'd0);
        chk("rst.load",    32'(reg_load),    32'd0);
        chk("rst.entrada", 32'(reg_entrada), 32'd0);
        chk("rst.ocupado", 32'(ocupado),     32'd0);
        chk("rst.dono",    32'(dono),        32'd0);
        rst_n = 1'b1;
        req   = 4'b0000;
        step;
        step;
        chk("idle.ocupado", 32'(ocupado),  32'd0);
        chk("idle.load",    32'(reg_load), 32'd0);
        chk("idle.gnt",     32'(gnt),      32'd0);

        // Rotation: all four requesting, each drops at its ack
        d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
        req  = 4'b1111;
        txn(2'd0, 16'h1111, 1'b1, 1'b0, "rot0");
        txn(2'd1, 16'h2222, 1'b1, 1'b0, "rot1");
        txn(2'd2, 16'h3333, 1'b1, 1'b0, "rot2");
        txn(2'd3, 16'h4444, 1'b1, 1'b0, "rot3");
        req[0] = 1'b1;
        txn(2'd0, 16'h1111, 1'b1, 1'b0, "rot0b");

        // Single write from requester 2; data scrambled after the load edge
        d[2] = 16'h00A5;
        req  = 4'b0100;
        txn(2'd2, 16'h00A5, 1'b1, 1'b1, "single");

        // Pointer is now 3: 3 beats 0 and 1, then the wrap favours 0 over 1
        d[0] = 16'h0A0A; d[1] = 16'h0B0B; d[3] = 16'h0D0D;
        req  = 4'b1011;
        txn(2'd3, 16'h0D0D, 1'b1, 1'b0, "wrap3");
        txn(2'd0, 16'h0A0A, 1'b1, 1'b0, "wrap0");

        // Late drop: requester 1 keeps req past its ack and gets a second write
        txn(2'd1, 16'h0B0B, 1'b0, 1'b0, "late1");
        d[1] = 16'h0C0C;
        txn(2'd1, 16'h0C0C, 1'b1, 1'b0, "late2");

        // Reset during CARREGA
        d[2] = 16'hBEEF;
        req  = 4'b0100;
        step;
        chk("abort.load_pre", 32'(reg_load), 32'd1);
        chk("abort.gnt_pre",  32'(gnt),      32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.load",    32'(reg_load),    32'd0);
        chk("abort.gnt",     32'(gnt),         32'd0);
        chk("abort.ocupado", 32'(ocupado),     32'd0);
        chk("abort.entrada", 32'(reg_entrada), 32'd0);
        step;
        chk("abort.ack",     32'(ack),         32'd0);
        chk("abort.reg",     32'(m_reg),       32'h0C0C);
        rst_n = 1'b1;
        req   = 4'b0000;
        step;
        chk("abort.ack2",    32'(ack),         32'd0);
        chk("abort.idle",    32'(ocupado),     32'd0);

        // Pointer was cleared by reset: 1 wins over 2
        d[1] = 16'h1234; d[2] = 16'h5678;
        req  = 4'b0110;
        txn(2'd1, 16'h1234, 1'b1, 1'b0, "prst1");
        txn(2'd2, 16'h5678, 1'b1, 1'b0, "prst2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arbitro_registrador.md
# arbitro_registrador

Round-robin arbiter and write sequencer that shares one 16-bit load-enabled holding register (`registrador`) among up to four requesters. It drives the register's data and load inputs and returns a grant/ack handshake to each requester. Only one write reaches the register per transaction, and requesters are served in rotating priority. It sits directly in front of the register, which remains a plain storage element.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..4). Index width is 2 bits.
- `WIDTH`, 16: data width, matching the register.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, N_REQ: write request, one bit per requester. A requester holds its bit high until it sees its `ack`.
- `dado`, input, N_REQ*WIDTH: packed write data. Requester i uses bits [i*WIDTH +: WIDTH].
- `gnt`, output, N_REQ: one-hot grant, high during the LOAD cycle.
- `ack`, output, N_REQ: one-hot, one-cycle completion pulse.
- `reg_entrada`, output, WIDTH: to the register data input.
- `reg_load`, output, 1: to the register load input.
- `ocupado`, output, 1: high whenever the FSM is not in OCIOSO.
- `dono`, output, 2: index of the last requester whose write completed.

## Operation
- FSM states: OCIOSO, CARREGA, CONFIRMA. Reset state is OCIOSO.
- Round-robin pointer `prio` (2 bits, reset 0):
  - Search order is prio, prio+1, … modulo N_REQ.
  - The first requester in that order with `req` high wins.
- OCIOSO:
  - If no `req` bit is high, stay.
  - Otherwise, at the edge: latch winner index w, set `reg_entrada` to dado[w], `reg_load` to 1, `gnt` to one-hot(w), and go to CARREGA.
- CARREGA (exactly one cycle):
  - The register captures `reg_entrada` at the closing edge.
  - At that edge: `reg_load` to 0, `gnt` to 0, `ack` to one-hot(w), `dono` to w, `prio` to (w+1) mod N_REQ, and go to CONFIRMA.
- CONFIRMA (exactly one cycle):
  - At the closing edge: `ack` to 0, go to OCIOSO.
  - A requester must drop `req` at the edge closing its ack cycle.
  - A `req` still high when OCIOSO is next sampled counts as a new request.
- `reg_entrada` holds its last value outside CARREGA; it changes only when entering CARREGA.
- All outputs are registered. No combinational path from `req`/`dado` to any output.
- Requester indices at or above N_REQ do not exist.
- The pointer wraps: when w = N_REQ-1, `prio` becomes 0.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state OCIOSO
  - `gnt`=0, `ack`=0
  - `reg_load`=0, `reg_entrada`=0
  - `ocupado`=0, `dono`=0, `prio`=0
- Reset mid-transaction: the transaction is abandoned.
  - No ack is issued and `reg_load` drops immediately.
  - Whether the register already captured the data depends only on whether the CARREGA-closing edge occurred before reset.
- Latency: `req` sampled high at edge E0 gives `reg_load`/`gnt` high during E0..E1.
  - The register captures at E1.
  - `ack` is high during E1..E2.
  - The FSM is back in OCIOSO after E2.
- Throughput: one write per 3 cycles maximum.
- `dado[w]` only needs to be valid at E0.
- Requests arriving during CARREGA/CONFIRMA wait. They are arbitrated at the first OCIOSO edge.
- Simultaneous requests are resolved by `prio` only. No starvation: each waiting requester is served within N_REQ transactions.
- A requester dropping `req` before its grant is simply not served. No error is raised.

## Test plan
- Reset check: hold `rst_n`=0 with random `req`/`dado` → all outputs 0. Release with `req`=0 → FSM stays idle, `ocupado`=0.
- Single write: req[2]=1, dado[2]=16'h00A5 at E0.
  - `reg_load`=1, `gnt`=4'b0100 for one cycle.
  - `ack`=4'b0100 on the next cycle.
  - Register output 16'h00A5 after E1.
  - `dono`=2, `prio`=3.
- Rotation: all four `req` held high, dropped individually after each ack → service order 0,1,2,3, then 0 again after wrap. `reg_load` never high in two consecutive cycles.
- Priority after wrap: serve requester 3 (`prio` becomes 0), then raise req[1] and req[0] together → requester 0 wins first.
- Late drop: requester 1 keeps `req` high one cycle past its ack, no other requests → a second write from requester 1 starts at the next OCIOSO edge.
- Reset during CARREGA: pulse `rst_n` low mid-cycle → `reg_load` and `gnt` go 0 immediately, no `ack` pulse, FSM in OCIOSO, `prio`=0.
